// File: rtl/mst_wr_arbiter.sv
// rtl/mst_wr_arbiter.sv - packet-level round-robin arbiter for the shared master-FIFO write port
// Two per-port word buffers feed one registered write port; packets are never interleaved.
module mst_wr_arbiter #(
  parameter int DEPTH       = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [17:0] a_din,
  input  logic        a_wr_en,
  output logic        a_full,
  input  logic [17:0] b_din,
  input  logic        b_wr_en,
  output logic        b_full,
  output logic [17:0] mst_din,
  output logic        mst_wr_en,
  input  logic        mst_full,
  output logic [1:0]  grant,
  output logic [7:0]  pkt_cnt_a,
  output logic [7:0]  pkt_cnt_b,
  output logic        err_ovf,
  output logic        err_orphan,
  output logic        err_stall,
  input  logic        err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0] LIMIT_C = 8'(STALL_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'b00, GNT_A = 2'b01, GNT_B = 2'b10} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [17:0]   mem_q [0:1][0:DEPTH-1];
  logic [AW-1:0] wptr_q [2], wptr_d [2];
  logic [AW-1:0] rptr_q [2], rptr_d [2];
  logic [CW-1:0] cnt_q [2], cnt_d [2];
  logic [17:0]   din [2];
  logic [17:0]   head [2];
  logic [1:0]    wr_en, ne, full, pop, push_ok, ovf, hdr;
  logic [17:0]   mst_din_q, mst_din_d;
  logic          mst_wr_en_q, mst_wr_en_d;
  logic [7:0]    pkt_cnt_a_q, pkt_cnt_a_d, pkt_cnt_b_q, pkt_cnt_b_d;
  logic [7:0]    stall_q, stall_d;
  logic          err_ovf_q, err_ovf_d, err_orphan_q, err_orphan_d, err_stall_q, err_stall_d;
  logic          orphan_set, stall_set;

  assign din[0]   = a_din;
  assign din[1]   = b_din;
  assign wr_en    = {b_wr_en, a_wr_en};
  assign head[0]  = mem_q[0][rptr_q[0]];
  assign head[1]  = mem_q[1][rptr_q[1]];
  assign ne       = {cnt_q[1] != '0, cnt_q[0] != '0};
  assign full     = {cnt_q[1] == DEPTH_C, cnt_q[0] == DEPTH_C};
  assign hdr      = {ne[1] & head[1][17], ne[0] & head[0][17]};
  // A push into a full buffer is still accepted when a word leaves in the same cycle.
  assign push_ok  = wr_en & (~full | pop);
  assign ovf      = wr_en & full & ~pop;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wptr_d[i] = wptr_q[i] + AW'(push_ok[i]);
      rptr_d[i] = rptr_q[i] + AW'(pop[i]);
      cnt_d[i]  = cnt_q[i] + CW'(push_ok[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    pop         = 2'b00;
    mst_din_d   = mst_din_q;
    mst_wr_en_d = 1'b0;
    pkt_cnt_a_d = pkt_cnt_a_q;
    pkt_cnt_b_d = pkt_cnt_b_q;
    orphan_set  = 1'b0;
    case (state_q)
      IDLE: begin
        for (int i = 0; i < 2; i++) begin
          if (ne[i] && !head[i][17]) begin
            pop[i]     = 1'b1;
            orphan_set = 1'b1;
          end
        end
        if (hdr[0] && hdr[1]) state_d = last_q ? GNT_A : GNT_B;
        else if (hdr[0])      state_d = GNT_A;
        else if (hdr[1])      state_d = GNT_B;
      end
      GNT_A: begin
        if (ne[0] && !mst_full) begin
          pop[0]      = 1'b1;
          mst_din_d   = head[0];
          mst_wr_en_d = 1'b1;
          if (head[0][16]) begin
            state_d     = IDLE;
            last_d      = 1'b0;
            pkt_cnt_a_d = pkt_cnt_a_q + 8'd1;
          end
        end
      end
      GNT_B: begin
        if (ne[1] && !mst_full) begin
          pop[1]      = 1'b1;
          mst_din_d   = head[1];
          mst_wr_en_d = 1'b1;
          if (head[1][16]) begin
            state_d     = IDLE;
            last_d      = 1'b1;
            pkt_cnt_b_d = pkt_cnt_b_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall counter saturates; the grant is kept so a packet is never cut short.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE || pop != 2'b00) stall_d = 8'd0;
    else if (stall_q != LIMIT_C)         stall_d = stall_q + 8'd1;
    stall_set    = (state_q != IDLE) && (stall_d == LIMIT_C);
    err_ovf_d    = (|ovf) | (err_ovf_q & ~err_clr);
    err_orphan_d = orphan_set | (err_orphan_q & ~err_clr);
    err_stall_d  = stall_set | (err_stall_q & ~err_clr);
  end

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_ok[i]) mem_q[i][wptr_q[i]] <= din[i];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      mst_din_q    <= '0;
      mst_wr_en_q  <= 1'b0;
      pkt_cnt_a_q  <= 8'd0;
      pkt_cnt_b_q  <= 8'd0;
      stall_q      <= 8'd0;
      err_ovf_q    <= 1'b0;
      err_orphan_q <= 1'b0;
      err_stall_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      mst_din_q    <= mst_din_d;
      mst_wr_en_q  <= mst_wr_en_d;
      pkt_cnt_a_q  <= pkt_cnt_a_d;
      pkt_cnt_b_q  <= pkt_cnt_b_d;
      stall_q      <= stall_d;
      err_ovf_q    <= err_ovf_d;
      err_orphan_q <= err_orphan_d;
      err_stall_q  <= err_stall_d;
    end
  end

  assign a_full     = full[0];
  assign b_full     = full[1];
  assign mst_din    = mst_din_q;
  assign mst_wr_en  = mst_wr_en_q;
  assign grant      = state_q;
  assign pkt_cnt_a  = pkt_cnt_a_q;
  assign pkt_cnt_b  = pkt_cnt_b_q;
  assign err_ovf    = err_ovf_q;
  assign err_orphan = err_orphan_q;
  assign err_stall  = err_stall_q;

endmodule

// File: tb/tb_mst_wr_arbiter.sv
// tb/tb_mst_wr_arbiter.sv - directed self-checking bench for mst_wr_arbiter
module tb_mst_wr_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [17:0] a_din = '0, b_din = '0;
  logic        a_wr_en = 1'b0, b_wr_en = 1'b0;
  logic        a_full, b_full;
  logic [17:0] mst_din;
  logic        mst_wr_en;
  logic        mst_full = 1'b0;
  logic [1:0]  grant;
  logic [7:0]  pkt_cnt_a, pkt_cnt_b;
  logic        err_ovf, err_orphan, err_stall;
  logic        err_clr = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int stray = 0;

  logic [17:0] aw [4] = '{18'h2A000, 18'h0A001, 18'h0A002, 18'h1A003};
  logic [17:0] bw [4] = '{18'h2B000, 18'h0B001, 18'h0B002, 18'h1B003};
  logic [17:0] cw [4] = '{18'h20100, 18'h00101, 18'h00102, 18'h10103};
  logic [17:0] dw [5] = '{18'h20B00, 18'h00B01, 18'h00B02, 18'h10B03, 18'h00B04};
  logic [17:0] fw [4] = '{18'h20500, 18'h00501, 18'h00502, 18'h00503};
  logic [17:0] gw [4] = '{18'h20600, 18'h00601, 18'h00602, 18'h00603};

  mst_wr_arbiter #(.DEPTH(4), .STALL_LIMIT(255)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .a_din(a_din), .a_wr_en(a_wr_en), .a_full(a_full),
    .b_din(b_din), .b_wr_en(b_wr_en), .b_full(b_full),
    .mst_din(mst_din), .mst_wr_en(mst_wr_en), .mst_full(mst_full),
    .grant(grant), .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b),
    .err_ovf(err_ovf), .err_orphan(err_orphan), .err_stall(err_stall),
    .err_clr(err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    a_wr_en = 1'b0; b_wr_en = 1'b0; mst_full = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_wr_en", 32'(mst_wr_en), 32'h0);
    chk("rst_din", 32'(mst_din), 32'h0);
    chk("rst_full", {30'd0, b_full, a_full}, 32'h0);
    chk("rst_cnts", {16'd0, pkt_cnt_b, pkt_cnt_a}, 32'h0);
    chk("rst_errs", {29'd0, err_ovf, err_orphan, err_stall}, 32'h0);

    // Single A packet
    for (int e = 0; e <= 5; e++) begin
      a_wr_en = (e < 3);
      a_din = (e == 0) ? 18'h29000 : (e == 1) ? 18'h01234 : 18'h15678;
      tick();
      if (e >= 1 && e <= 3) chk($sformatf("t1_grant_e%0d", e), 32'(grant), 32'h1);
      if (e >= 1) chk($sformatf("t1_wr_e%0d", e), 32'(mst_wr_en), 32'((e >= 2 && e <= 4) ? 1 : 0));
      if (e == 2) chk("t1_din_e2", 32'(mst_din), 32'h29000);
      if (e == 3) chk("t1_din_e3", 32'(mst_din), 32'h01234);
      if (e == 4) chk("t1_din_e4", 32'(mst_din), 32'h15678);
      if (e == 4) chk("t1_pkt_a", 32'(pkt_cnt_a), 32'h1);
      if (e == 5) chk("t1_idle", 32'(grant), 32'h0);
    end

    // Contention from reset, then a second simultaneous pair
    do_reset();
    for (int e = 0; e <= 22; e++) begin
      a_wr_en = (e < 4) || (e >= 11 && e < 15);
      b_wr_en = a_wr_en;
      a_din = aw[(e < 4) ? e : (e >= 11 && e < 15) ? e - 11 : 0];
      b_din = bw[(e < 4) ? e : (e >= 11 && e < 15) ? e - 11 : 0];
      tick();
      if (e == 1) chk("t2_first_grant", 32'(grant), 32'h1);
      if (e >= 2 && e <= 10) begin
        chk($sformatf("t2_wr_e%0d", e), 32'(mst_wr_en), 32'((e == 6) ? 0 : 1));
        if (e >= 2 && e <= 5) chk($sformatf("t2_din_e%0d", e), 32'(mst_din), 32'(aw[e - 2]));
        if (e >= 7) chk($sformatf("t2_din_e%0d", e), 32'(mst_din), 32'(bw[e - 7]));
      end
      if (e == 6) chk("t2_grant_b", 32'(grant), 32'h2);
      if (e == 12) chk("t2_second_grant", 32'(grant), 32'h1);
      if (e == 13) chk("t2_second_hdr", 32'(mst_din), 32'(aw[0]));
      if (e == 17) chk("t2_second_grant_b", 32'(grant), 32'h2);
    end
    chk("t2_pkt_cnts", {16'd0, pkt_cnt_b, pkt_cnt_a}, 32'h0202);

    // Backpressure for 5 cycles mid-packet
    do_reset();
    for (int e = 0; e <= 11; e++) begin
      a_wr_en = (e < 4);
      a_din = cw[(e < 4) ? e : 0];
      mst_full = (e >= 3 && e <= 7);
      tick();
      if (e >= 1) chk($sformatf("t3_wr_e%0d", e), 32'(mst_wr_en), 32'((e == 2 || (e >= 8 && e <= 10)) ? 1 : 0));
      if (e == 2) chk("t3_din_e2", 32'(mst_din), 32'(cw[0]));
      if (e >= 8 && e <= 10) chk($sformatf("t3_din_e%0d", e), 32'(mst_din), 32'(cw[e - 7]));
    end
    chk("t3_pkt_a", 32'(pkt_cnt_a), 32'h1);
    mst_full = 1'b0;

    // Overflow on B while the master FIFO is full, then an orphan word on idle A
    do_reset();
    for (int e = 0; e <= 13; e++) begin
      mst_full = (e <= 5);
      b_wr_en = (e < 5);
      b_din = dw[(e < 5) ? e : 0];
      a_wr_en = (e == 11);
      a_din = 18'h00042;
      tick();
      if (e == 3) chk("t4_b_full", 32'(b_full), 32'h1);
      if (e == 3) chk("t4_ovf_before", 32'(err_ovf), 32'h0);
      if (e == 4) chk("t4_ovf", 32'(err_ovf), 32'h1);
      if (e >= 6 && e <= 9) chk($sformatf("t4_din_e%0d", e), 32'(mst_din), 32'(dw[e - 6]));
      if (e >= 6 && e <= 10) chk($sformatf("t4_wr_e%0d", e), 32'(mst_wr_en), 32'((e <= 9) ? 1 : 0));
      if (e == 9) chk("t4_pkt_b", 32'(pkt_cnt_b), 32'h1);
      if (e == 11) chk("t4_orphan_before", 32'(err_orphan), 32'h0);
      if (e == 12) chk("t4_orphan", 32'(err_orphan), 32'h1);
      if (e == 12) chk("t4_no_grant", 32'(grant), 32'h0);
      if (e == 13) chk("t4_orphan_not_sent", 32'(mst_wr_en), 32'h0);
    end

    // Stall on A, completion, then err_clr
    for (int e = 0; e <= 260; e++) begin
      a_wr_en = (e == 0 || e == 258);
      a_din = (e == 0) ? 18'h20300 : 18'h10301;
      err_clr = (e == 260);
      tick();
      if (e >= 3 && e <= 258 && mst_wr_en) stray++;
      if (e == 2) chk("t5_hdr", {13'd0, mst_wr_en, mst_din}, {13'd0, 1'b1, 18'h20300});
      if (e == 256) chk("t5_stall_before", 32'(err_stall), 32'h0);
      if (e == 257) chk("t5_stall", 32'(err_stall), 32'h1);
      if (e == 257) chk("t5_grant_held", 32'(grant), 32'h1);
      if (e == 259) begin
        chk("t5_last", {13'd0, mst_wr_en, mst_din}, {13'd0, 1'b1, 18'h10301});
        chk("t5_idle", 32'(grant), 32'h0);
        chk("t5_pkt_a", 32'(pkt_cnt_a), 32'h1);
        chk("t5_errs_set", {29'd0, err_ovf, err_orphan, err_stall}, 32'h7);
      end
      if (e == 260) chk("t5_errs_clr", {29'd0, err_ovf, err_orphan, err_stall}, 32'h0);
    end
    chk("t5_no_stray_writes", 32'(stray), 32'h0);
    err_clr = 1'b0;

    // Asynchronous reset in the middle of a B packet
    for (int e = 0; e <= 5; e++) begin
      b_wr_en = (e <= 3);
      b_din = fw[(e <= 3) ? e : 0];
      a_wr_en = (e >= 1 && e <= 4);
      a_din = gw[(e >= 1 && e <= 4) ? e - 1 : 0];
      tick();
      if (e >= 2) chk($sformatf("t6_din_e%0d", e), 32'(mst_din), 32'(fw[e - 2]));
    end
    chk("t6_pre_grant", 32'(grant), 32'h2);
    chk("t6_pre_a_full", 32'(a_full), 32'h1);
    chk("t6_pre_wr", 32'(mst_wr_en), 32'h1);
    chk("t6_pre_cnts", {16'd0, pkt_cnt_b, pkt_cnt_a}, 32'h0101);
    sys_rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 32'h0);
    chk("t6_wr", 32'(mst_wr_en), 32'h0);
    chk("t6_full", {30'd0, b_full, a_full}, 32'h0);
    chk("t6_cnts", {16'd0, pkt_cnt_b, pkt_cnt_a}, 32'h0);
    sys_rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
